// File: rtl/opcode_frame_pkg.sv
// Shared definitions for the opcode nibble link: header nibbles, framer states, frame length.
// Frame length depends on OPCODE_TX_PARITY_EN.
package opcode_frame_pkg;

    localparam logic [3:0] HDR0 = 4'h5;
    localparam logic [3:0] HDR1 = 4'h5;
    localparam logic [3:0] HDR2 = 4'hD;
    localparam logic [3:0] HDR3 = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_OPH,
        ST_OPL,
        ST_PAR,
        ST_GAP
    } tx_state_e;

`ifdef OPCODE_TX_PARITY_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

    function automatic logic [3:0] hdr_nibble(input logic [1:0] idx);
        case (idx)
            2'd0:    return HDR0;
            2'd1:    return HDR1;
            2'd2:    return HDR2;
            default: return HDR3;
        endcase
    endfunction

endpackage

// File: rtl/opcode_frame_tx_hold_buf.sv
// One-byte holding buffer in front of the framer; the engine empties it with take.
module opcode_hold_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    input  logic       take,
    output logic       din_rdy,
    output logic       hold_full,
    output logic [7:0] hold_data
);

    // take and an accept are mutually exclusive: take needs a full buffer, accept an empty one
    assign din_rdy = ~hold_full & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else if (take) begin
            hold_full <= 1'b0;
        end else if (din_vld && din_rdy) begin
            hold_full <= 1'b1;
            hold_data <= din;
        end
    end

endmodule

// File: rtl/opcode_frame_tx.sv
// Nibble-stream framer: 5,5,D,5, opcode high, opcode low [, parity], then GAP idle cycles.
// Optional parity nibble enabled by defining OPCODE_TX_PARITY_EN.
//
//   state   | meaning
//   IDLE    | waiting for a byte in the hold buffer
//   HDR     | emitting header nibble hdr_cnt
//   OPH     | emitting opcode high nibble
//   OPL     | emitting opcode low nibble
//   PAR     | emitting high^low parity nibble (parity builds only)
//   GAP     | dout_vld low, gap_cnt counting down to zero
module opcode_frame_tx #(
    parameter int GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
    output logic [3:0] dout,
    output logic       dout_vld,
    output logic       busy
);
    import opcode_frame_pkg::*;

    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    tx_state_e  state;
    logic [1:0] hdr_cnt;
    logic [3:0] gap_cnt;
    logic [7:0] op_reg;
    logic       hold_full;
    logic [7:0] hold_data;
    logic       last_data;
    logic       load_now;

    opcode_hold_buf u_hold (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .take      (load_now),
        .din_rdy   (din_rdy),
        .hold_full (hold_full),
        .hold_data (hold_data)
    );

`ifdef OPCODE_TX_PARITY_EN
    assign last_data = (state == ST_PAR);
`else
    assign last_data = (state == ST_OPL);
`endif

    // Loading straight out of the last data nibble or last gap cycle keeps the period at len+GAP
    assign load_now = hold_full & ((state == ST_IDLE) |
                                   (last_data & (GAP == 0)) |
                                   ((state == ST_GAP) & (gap_cnt == 4'd0)));

    assign busy = (state != ST_IDLE) | hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hdr_cnt  <= 2'd0;
            gap_cnt  <= 4'd0;
            op_reg   <= 8'h00;
            dout     <= 4'h0;
            dout_vld <= 1'b0;
        end else begin
            dout     <= 4'h0;
            dout_vld <= 1'b0;
            if (load_now) begin
                state    <= ST_HDR;
                hdr_cnt  <= 2'd0;
                op_reg   <= hold_data;
                dout     <= HDR0;
                dout_vld <= 1'b1;
            end else begin
                case (state)
                    ST_HDR: begin
                        dout_vld <= 1'b1;
                        if (hdr_cnt == 2'd3) begin
                            state <= ST_OPH;
                            dout  <= op_reg[7:4];
                        end else begin
                            hdr_cnt <= hdr_cnt + 2'd1;
                            dout    <= hdr_nibble(hdr_cnt + 2'd1);
                        end
                    end
                    ST_OPH: begin
                        state    <= ST_OPL;
                        dout     <= op_reg[3:0];
                        dout_vld <= 1'b1;
                    end
`ifdef OPCODE_TX_PARITY_EN
                    ST_OPL: begin
                        state    <= ST_PAR;
                        dout     <= op_reg[7:4] ^ op_reg[3:0];
                        dout_vld <= 1'b1;
                    end
                    ST_PAR: begin
                        if (GAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LAST;
                        end
                    end
`else
                    ST_OPL: begin
                        if (GAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LAST;
                        end
                    end
`endif
                    ST_GAP: begin
                        if (gap_cnt == 4'd0) state <= ST_IDLE;
                        else                 gap_cnt <= gap_cnt - 4'd1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_opcode_frame_tx.sv
// Directed bench for opcode_frame_tx: dut A uses GAP=2, dut B uses GAP=0.
module tb_opcode_frame_tx;

    localparam int GAP_A = 2;
    localparam int GAP_B = 0;
`ifdef OPCODE_TX_PARITY_EN
    localparam int FL = 7;
`else
    localparam int FL = 6;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] din_a = 8'h00, din_b = 8'h00;
    logic       vld_a = 1'b0, vld_b = 1'b0;
    logic       rdy_a, rdy_b, dv_a, dv_b, busy_a, busy_b;
    logic [3:0] dout_a, dout_b;

    opcode_frame_tx #(.GAP(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_vld(vld_a), .din_rdy(rdy_a),
        .dout(dout_a), .dout_vld(dv_a), .busy(busy_a));

    opcode_frame_tx #(.GAP(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_vld(vld_b), .din_rdy(rdy_b),
        .dout(dout_b), .dout_vld(dv_b), .busy(busy_b));

    // Model: a byte buffer plus a schedule of upcoming output slots {vld, nibble}.
    // When the schedule runs dry and a byte is waiting, a whole frame plus its gap is queued.
    logic [4:0] m_pend [2][32];
    int         m_cnt  [2] = '{0, 0};
    logic       m_full [2] = '{1'b0, 1'b0};
    logic [7:0] m_byte [2];
    logic       m_vld  [2] = '{1'b0, 1'b0};
    logic [3:0] m_dout [2] = '{4'h0, 4'h0};
    logic       m_act  [2] = '{1'b0, 1'b0};

    task automatic m_push(input int i, input logic [4:0] e);
        m_pend[i][m_cnt[i]] = e;
        m_cnt[i] = m_cnt[i] + 1;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       acc;
            logic [7:0] in_b;
            logic       in_v;
            int         gap;
            in_b = (i == 0) ? din_a : din_b;
            in_v = (i == 0) ? vld_a : vld_b;
            gap  = (i == 0) ? GAP_A : GAP_B;
            if (rst) begin
                m_full[i] = 1'b0;
                m_cnt[i]  = 0;
                m_vld[i]  = 1'b0;
                m_dout[i] = 4'h0;
                m_act[i]  = 1'b0;
            end else begin
                acc = in_v && !m_full[i];
                if (m_cnt[i] == 0 && m_full[i]) begin
                    m_push(i, 5'h15); m_push(i, 5'h15); m_push(i, 5'h1D); m_push(i, 5'h15);
                    m_push(i, {1'b1, m_byte[i][7:4]});
                    m_push(i, {1'b1, m_byte[i][3:0]});
`ifdef OPCODE_TX_PARITY_EN
                    m_push(i, {1'b1, m_byte[i][7:4] ^ m_byte[i][3:0]});
`endif
                    for (int g = 0; g < gap; g++) m_push(i, 5'h00);
                    m_full[i] = 1'b0;
                end
                if (m_cnt[i] > 0) begin
                    {m_vld[i], m_dout[i]} = m_pend[i][0];
                    for (int k = 0; k < 31; k++) m_pend[i][k] = m_pend[i][k+1];
                    m_cnt[i] = m_cnt[i] - 1;
                    m_act[i] = 1'b1;
                end else begin
                    m_vld[i]  = 1'b0;
                    m_dout[i] = 4'h0;
                    m_act[i]  = 1'b0;
                end
                if (acc) begin
                    m_full[i] = 1'b1;
                    m_byte[i] = in_b;
                end
            end
        end
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] lg     [2][128];
    int         lg_n   [2] = '{0, 0};
    int         run    [2] = '{0, 0};
    int         maxrun [2] = '{0, 0};

    task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, i, $time, act, exp);
        end
    endtask

    task automatic check_dut(input int i);
        logic       av, ar, ab;
        logic [3:0] ad;
        av = (i == 0) ? dv_a   : dv_b;
        ar = (i == 0) ? rdy_a  : rdy_b;
        ab = (i == 0) ? busy_a : busy_b;
        ad = (i == 0) ? dout_a : dout_b;
        cmp("dout_vld", i, 32'(av), 32'(m_vld[i]));
        cmp("dout",     i, 32'(ad), 32'(m_dout[i]));
        cmp("din_rdy",  i, 32'(ar), 32'(!m_full[i] && !rst));
        cmp("busy",     i, 32'(ab), 32'(m_act[i] || m_full[i]));
        if (av) begin
            if (lg_n[i] < 128) lg[i][lg_n[i]] = ad;
            lg_n[i] = lg_n[i] + 1;
            run[i]  = run[i] + 1;
            if (run[i] > maxrun[i]) maxrun[i] = run[i];
        end else begin
            run[i] = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    // Leaves din_vld high after the accepting edge so back-to-back sends need no bubble.
    task automatic send(input int i, input logic [7:0] b);
        logic ok;
        logic r;
        ok = 1'b0;
        if (i == 0) begin din_a = b; vld_a = 1'b1; end
        else        begin din_b = b; vld_b = 1'b1; end
        for (int t = 0; t < 100 && !ok; t++) begin
            r = (i == 0) ? rdy_a : rdy_b;
            tick();
            if (r) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout dut%0d byte %0h: got no din_rdy, expected acceptance", i, b);
        end
    endtask

    task automatic drop(input int i);
        if (i == 0) vld_a = 1'b0;
        else        vld_b = 1'b0;
    endtask

    task automatic check_log(input string nm, input int i, input int mark, input int n,
                             input logic [127:0] exp);
        logic [127:0] act;
        int           got;
        act = '0;
        got = lg_n[i] - mark;
        for (int k = mark; k < lg_n[i] && k < 128; k++) act = (act << 4) | 128'(lg[i][k]);
        n_vec++;
        if (got != n || act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d nibbles %0h, expected %0d nibbles %0h",
                     nm, i, got, act, n, exp);
        end
    endtask

    initial begin
        int  mark;
        logic found;

        tick();
        cmp("rst_rdy", 0, 32'(rdy_a), 32'd0);
        cmp("rst_vld", 0, 32'(dv_a), 32'd0);
        cmp("rst_busy", 0, 32'(busy_a), 32'd0);
        run_cycles(2);
        rst = 1'b0;
        tick();
        cmp("post_rst_rdy", 0, 32'(rdy_a), 32'd1);

        // Single byte: latency and frame content
        mark = lg_n[0];
        send(0, 8'h81);
        drop(0);
        cmp("lat_edge_k", 0, 32'(dv_a), 32'd0);
        tick();
        cmp("lat_first", 0, {27'd0, dv_a, dout_a}, 32'h15);
        run_cycles(20);
        cmp("busy_after_gap", 0, 32'(busy_a), 32'd0);
`ifdef OPCODE_TX_PARITY_EN
        check_log("frame_81", 0, mark, 7, 128'h55D5819);
`else
        check_log("frame_81", 0, mark, 6, 128'h55D581);
`endif

        mark = lg_n[0];
        send(0, 8'hA5);
        drop(0);
        run_cycles(20);
`ifdef OPCODE_TX_PARITY_EN
        check_log("frame_a5", 0, mark, 7, 128'h55D5A5F);
`else
        check_log("frame_a5", 0, mark, 6, 128'h55D5A5);
`endif

        // Back-to-back with GAP=2
        mark = lg_n[0];
        send(0, 8'hA3);
        send(0, 8'h4C);
        drop(0);
        run_cycles(30);
`ifdef OPCODE_TX_PARITY_EN
        check_log("b2b", 0, mark, 14, 128'h55D5A3955D54C8);
`else
        check_log("b2b", 0, mark, 12, 128'h55D5A355D54C);
`endif

        // Backpressure
        mark = lg_n[0];
        send(0, 8'h11);
        send(0, 8'h22);
        cmp("bp_rdy_low", 0, 32'(rdy_a), 32'd0);
        send(0, 8'h33);
        drop(0);
        run_cycles(40);
`ifdef OPCODE_TX_PARITY_EN
        check_log("backpressure", 0, mark, 21, 128'h55D511055D522055D5330);
`else
        check_log("backpressure", 0, mark, 18, 128'h55D51155D52255D533);
`endif

        // GAP=0 contiguous frames
        mark = lg_n[1];
        send(1, 8'h5D);
        send(1, 8'hF0);
        drop(1);
        run_cycles(30);
`ifdef OPCODE_TX_PARITY_EN
        check_log("gap0", 1, mark, 14, 128'h55D55D855D5F0F);
`else
        check_log("gap0", 1, mark, 12, 128'h55D55D55D5F0);
`endif
        cmp("gap0_run", 1, 32'(maxrun[1]), 32'(2 * FL));

        // Reset during the OPH nibble with a byte held
        mark = lg_n[0];
        send(0, 8'h81);
        send(0, 8'h42);
        drop(0);
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (dv_a && dout_a == 4'h8) found = 1'b1;
            else tick();
        end
        cmp("oph_seen", 0, 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        cmp("rst_trunc_vld", 0, 32'(dv_a), 32'd0);
        rst = 1'b0;
        run_cycles(30);
        check_log("truncated", 0, mark, 5, 128'h55D58);

        mark = lg_n[0];
        send(0, 8'h07);
        drop(0);
        run_cycles(20);
`ifdef OPCODE_TX_PARITY_EN
        check_log("frame_07", 0, mark, 7, 128'h55D5077);
`else
        check_log("frame_07", 0, mark, 6, 128'h55D507);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/opcode_frame_tx.md
# opcode_frame_tx

Transmit-side framer for the temperature-monitor nibble link: accepts one opcode byte per handshake and serialises it as a framed 4-bit stream: header nibbles 5, 5, D, 5, then the opcode high nibble, then the opcode low nibble. It is the link partner of the opcode detector and drives the same `dout`/`dout_vld` nibble interface that the detector consumes on its `din`/`din_vld`. A one-byte holding buffer lets upstream logic queue the next opcode while the current frame is on the wire.

## Interface
- `GAP`, default 2: idle cycles with `dout_vld`=0 inserted after every frame. Range 0..15; 0 means frames run back-to-back.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  8  opcode byte.
- `din_vld`  in  1  `din` is valid this cycle.
- `din_rdy`  out  1  block can accept a byte; a transfer occurs on an edge where `din_vld` & `din_rdy`.
- `dout`  out  4  nibble stream, registered.
- `dout_vld`  out  1  `dout` is valid this cycle, registered.
- `busy`  out  1  a frame is in progress, in gap, or the hold buffer is full.

## Operation
- Hold buffer: one byte plus `hold_full`. An accept sets `hold_full` and captures `din`. `din_rdy` = ~`hold_full` & ~`rst`. There is no same-cycle refill: `din_rdy` rises the cycle after the engine empties the buffer.
- FSM states: IDLE, HDR, OPH, OPL, [PAR], GAP.
  - IDLE: when `hold_full`, load the byte into `op_reg`, clear `hold_full`, and go to HDR with `hdr_cnt`=0.
  - HDR: emit `hdr[hdr_cnt]` = {5, 5, D, 5}. Go to OPH after `hdr_cnt`=3.
  - OPH: emit `op_reg[7:4]`.
  - OPL: emit `op_reg[3:0]`. Next state is PAR if parity is compiled in, otherwise GAP; if `GAP`=0, skip GAP (see below).
  - GAP: `dout_vld`=0 for `GAP` cycles, then IDLE.
  - With `GAP`=0, the last data state goes straight to HDR if `hold_full` (loading the byte), else to IDLE. This gives contiguous frames.
- `dout_vld`=1 exactly in the HDR, OPH, OPL and PAR states. `dout` holds 0 whenever `dout_vld`=0.
- `busy` = (state != IDLE) | `hold_full`.

## Timing
- Reset values: `dout`=0, `dout_vld`=0, `din_rdy`=0 while `rst`=1 and 1 on the first cycle after, `busy`=0. State = IDLE, `hold_full`=0, counters = 0.
- Latency: a byte accepted at edge k into an idle block makes the first header nibble appear with `dout_vld` on the cycle following edge k+1.
- Frame length is 6 valid cycles (7 with parity). Period is 6+`GAP` cycles (7+`GAP` with parity).
- Reset mid-frame: the frame is truncated, `dout_vld`=0 the cycle after the reset edge, and any held byte is discarded.
- `din_vld` while `din_rdy`=0: the byte is ignored. Upstream must hold it.
- `din` changing while `din_rdy`=0 has no effect. `op_reg` is stable for the whole frame.

## Configuration
- `OPCODE_TX_PARITY_EN` defined: a PAR state follows OPL and emits `op_reg[7:4]` ^ `op_reg[3:0]` with `dout_vld`=1. Frame is 7 nibbles.
- `OPCODE_TX_PARITY_EN` undefined: no PAR state. Frame is 6 nibbles.

## Structure
- Package `opcode_frame_pkg` holds:
  - the header nibble constants `HDR0`..`HDR3` = 5, 5, D, 5;
  - the state enum;
  - the frame-length localparam that depends on `OPCODE_TX_PARITY_EN`.
  - The opcode detector imports the same header constants.
- One sub-module, `opcode_hold_buf`: the 1-deep byte buffer with its valid/ready handshake and `take` input. The FSM lives in the top module.

## Test plan
- Single byte: reset, then accept 0x81 → one cycle later `dout` = 5, 5, D, 5, 8, 1 with `dout_vld` high for exactly 6 cycles, then low. `busy` falls after the gap.
- Back-to-back, `GAP`=2: send 0xA3 and then 0x4C as soon as `din_rdy` allows → frames 5,5,D,5,A,3 and 5,5,D,5,4,C, separated by exactly 2 `dout_vld`=0 cycles.
- Backpressure: hold `din_vld` high with 0x11, 0x22, 0x33 in turn → `din_rdy` deasserts while the buffer is full. No byte is lost or duplicated, and frames come out in order.
- `GAP`=0: queue 0x5D then 0xF0 → 12 contiguous valid nibbles: 5,5,D,5,5,D,5,5,D,5,F,0.
- Reset mid-frame: assert `rst` during the OPH nibble of 0x81 with 0x42 held → `dout_vld`=0 the next cycle and no 0x42 frame appears. A fresh 0x07 afterwards frames correctly.
- Parity (`OPCODE_TX_PARITY_EN` defined): 0x81 → 5,5,D,5,8,1,9. 0xA5 → 5,5,D,5,A,5,F.
